control_scoreboard: RTL

Parametrised self-checking scoreboard for datapath/control verification; successor to the static expected-control table.
- The bench pushes expected control words, each with a per-bit care mask, into an in-order queue.
- The DUT's observed control word is compared against the queue head whenever it is valid.
- Keeps pass/fail counts, a sticky verdict FSM, and a capture of the first failure.
- Sits beside the DUT in datapath/control-unit benches.

---
 rtl/control_scoreboard_pkg.sv | 25 ++
 rtl/control_scoreboard_if.sv | 44 ++++
 rtl/control_scoreboard_sb_fifo.sv | 72 +++++++
 rtl/control_scoreboard.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/control_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// control_scoreboard_pkg
// Shared types for the control-word scoreboard.
//   sb_state_t : verdict encoding driven on the scoreboard's state output
//                (0 IDLE, 1 PASS, 2 FAIL).
//   sb_entry_t : one expected-queue entry {ctrl, mask} at the default
//                control-word width. The scoreboard re-declares the same
//                layout at its own CTRL_W so non-default widths work.
// -----------------------------------------------------------------------------
package control_scoreboard_pkg;

  localparam int SB_CTRL_W = 16;

  typedef enum logic [1:0] {
    SB_IDLE = 2'd0,
    SB_PASS = 2'd1,
    SB_FAIL = 2'd2
  } sb_state_t;

  typedef struct packed {
    logic [SB_CTRL_W-1:0] ctrl;
    logic [SB_CTRL_W-1:0] mask;
  } sb_entry_t;

endpackage

// File: rtl/control_scoreboard_if.sv
// -----------------------------------------------------------------------------
// control_scoreboard_if
// Bundles the scoreboard's expected-push channel, observed-word input, flush
// and all status/capture outputs.
//   master : bench side (drives exp_*, obs_*, flush; reads results)
//   slave  : scoreboard side
// -----------------------------------------------------------------------------
interface control_scoreboard_if #(
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              exp_valid;
  logic              exp_ready;
  logic [CTRL_W-1:0] exp_ctrl;
  logic [CTRL_W-1:0] exp_mask;
  logic              obs_valid;
  logic [CTRL_W-1:0] obs_ctrl;
  logic              flush;
  logic              match;
  logic              mismatch;
  logic              underflow;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  pass_count;
  logic [CNT_W-1:0]  fail_count;
  logic [1:0]        state;
  logic [CNT_W-1:0]  ff_index;
  logic [CTRL_W-1:0] ff_exp;
  logic [CTRL_W-1:0] ff_obs;

  modport master (
    output exp_valid, exp_ctrl, exp_mask, obs_valid, obs_ctrl, flush,
    input  exp_ready, match, mismatch, underflow, level,
           pass_count, fail_count, state, ff_index, ff_exp, ff_obs
  );

  modport slave (
    input  exp_valid, exp_ctrl, exp_mask, obs_valid, obs_ctrl, flush,
    output exp_ready, match, mismatch, underflow, level,
           pass_count, fail_count, state, ff_index, ff_exp, ff_obs
  );
endinterface

// File: rtl/control_scoreboard_sb_fifo.sv
// -----------------------------------------------------------------------------
// sb_fifo
// Synchronous FIFO of DEPTH entries, W bits each, with flush.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din at tail (ignored when full)
//   pop      : drop head (ignored when empty)
//   flush    : empty the FIFO; wins over push/pop in the same cycle
//   dout     : current head (combinational read so it can be compared in the
//              same cycle the observation arrives)
//   level    : entries held, 0..DEPTH
//   full, empty
// -----------------------------------------------------------------------------
module sb_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];
  assign level   = level_reg;

  // Storage carries no reset; pointers/level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr_reg] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)
        level_reg <= level_reg + 1'b1;
      else if (do_pop && !do_push)
        level_reg <= level_reg - 1'b1;
    end
  end
endmodule

// File: rtl/control_scoreboard.sv
// -----------------------------------------------------------------------------
// control_scoreboard
// In-order self-checking scoreboard for control words. Expected words with a
// per-bit care mask are queued; each valid observed word is compared against
// the queue head. Registered one-cycle match/mismatch/underflow pulses,
// saturating pass/fail counters, a sticky verdict FSM and a first-failure
// capture are provided.
//   clk, rst : clock, asynchronous active-high reset
//   sb       : control_scoreboard_if.slave (exp_*, obs_*, flush, results)
// Build option: SCOREBOARD_STOP_ON_FAIL_EN -- once the verdict is FAIL the
// queue is frozen (exp_ready=0, no pops, obs ignored, counters hold).
// -----------------------------------------------------------------------------
module control_scoreboard
  import control_scoreboard_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  control_scoreboard_if.slave  sb
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [CTRL_W-1:0] mask;
  } entry_t;

  entry_t            push_entry;
  entry_t            head;
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic              frozen;
  logic              push;
  logic              obs_take;
  logic              do_cmp;
  logic              do_uf;
  logic              cmp_fail;
  logic              pass_evt;
  logic              fail_evt;

  sb_state_t         state_reg;
  sb_state_t         state_next;
  logic              match_reg;
  logic              mismatch_reg;
  logic              underflow_reg;
  logic [CNT_W-1:0]  pass_count_reg;
  logic [CNT_W-1:0]  fail_count_reg;
  logic [CNT_W-1:0]  txn_index_reg;
  logic [CNT_W-1:0]  ff_index_reg;
  logic [CTRL_W-1:0] ff_exp_reg;
  logic [CTRL_W-1:0] ff_obs_reg;

`ifdef SCOREBOARD_STOP_ON_FAIL_EN
  assign frozen = (state_reg == SB_FAIL);
`else
  assign frozen = 1'b0;
`endif

  assign sb.exp_ready = !full && !frozen;
  assign push         = sb.exp_valid && sb.exp_ready;
  assign push_entry   = '{ctrl: sb.exp_ctrl, mask: sb.exp_mask};

  // Comparison happens against the pre-edge head, so an obs in a flush
  // cycle still sees the entry that the flush is about to discard.
  assign obs_take = sb.obs_valid && !frozen;
  assign do_cmp   = obs_take && !empty;
  assign do_uf    = obs_take && empty;
  assign cmp_fail = |((sb.obs_ctrl ^ head.ctrl) & head.mask);
  assign pass_evt = do_cmp && !cmp_fail;
  assign fail_evt = (do_cmp && cmp_fail) || do_uf;

  sb_fifo #(
    .W     (2*CTRL_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (do_cmp),
    .flush (sb.flush),
    .din   (push_entry),
    .dout  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Verdict FSM: FAIL is absorbing until reset.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SB_IDLE: begin
        if (fail_evt)
          state_next = SB_FAIL;
        else if (pass_evt)
          state_next = SB_PASS;
      end
      SB_PASS: begin
        if (fail_evt)
          state_next = SB_FAIL;
      end
      SB_FAIL: state_next = SB_FAIL;
      default: state_next = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= SB_IDLE;
    else
      state_reg <= state_next;
  end

  // Result pulses and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_reg      <= 1'b0;
      mismatch_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
      pass_count_reg <= '0;
      fail_count_reg <= '0;
      txn_index_reg  <= '0;
    end else begin
      match_reg     <= pass_evt;
      mismatch_reg  <= do_cmp && cmp_fail;
      underflow_reg <= do_uf;
      if (pass_evt && (pass_count_reg != '1))
        pass_count_reg <= pass_count_reg + 1'b1;
      if (fail_evt && (fail_count_reg != '1))
        fail_count_reg <= fail_count_reg + 1'b1;
      if (obs_take && (txn_index_reg != '1))
        txn_index_reg <= txn_index_reg + 1'b1;
    end
  end

  // First-failure capture: loaded only on the transition into FAIL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_index_reg <= '0;
      ff_exp_reg   <= '0;
      ff_obs_reg   <= '0;
    end else if (fail_evt && (state_reg != SB_FAIL)) begin
      ff_index_reg <= txn_index_reg;
      ff_exp_reg   <= do_uf ? '0 : head.ctrl;
      ff_obs_reg   <= sb.obs_ctrl;
    end
  end

  assign sb.match      = match_reg;
  assign sb.mismatch   = mismatch_reg;
  assign sb.underflow  = underflow_reg;
  assign sb.level      = level;
  assign sb.pass_count = pass_count_reg;
  assign sb.fail_count = fail_count_reg;
  assign sb.state      = state_reg;
  assign sb.ff_index   = ff_index_reg;
  assign sb.ff_exp     = ff_exp_reg;
  assign sb.ff_obs     = ff_obs_reg;
endmodule
